// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall (LU_STALL bubbles), data-memory freeze with
// sticky timeout, branch flush. Optional performance counters under `HAZARD_PERF_EN.
module hazard_ctrl_unit #(
    parameter int REG_W        = 5,
    parameter int LU_STALL     = 1,
    parameter int MEM_WAIT_MAX = 15,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  rs1_id,
    input  logic [REG_W-1:0]  rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              mem_read_ex,
    input  logic [REG_W-1:0]  rd_ex,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    output logic              pc_write_enable,
    output logic              if_id_write_enable,
    output logic              id_ex_write_enable,
    output logic              ex_mem_write_enable,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              stall_active,
    output logic              mem_timeout,
    input  logic              perf_clear,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {RUN = 2'd0, LU_HOLD = 2'd1, MEM_WAIT = 2'd2} state_t;

    localparam logic [1:0] LU_CNT_INIT  = 2'(LU_STALL - 1);
    localparam logic [7:0] WAIT_MAX_C   = 8'(MEM_WAIT_MAX);

    state_t     state_q, state_d, ret_q, ret_d, eff_state;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       lu_hazard, branch_flush;

    assign state_dbg   = state_q;
    assign mem_timeout = timeout_q;

    always_comb begin
        lu_hazard = mem_read_ex && (rd_ex != '0) &&
                    ((rs1_used_id && (rd_ex == rs1_id)) || (rs2_used_id && (rd_ex == rs2_id)));
        // Leaving MEM_WAIT behaves exactly like the state that was frozen, in the same cycle.
        eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

        state_d             = state_q;
        ret_d               = ret_q;
        lu_cnt_d            = lu_cnt_q;
        wait_cnt_d          = '0;
        timeout_d           = timeout_q;
        branch_flush        = 1'b0;
        pc_write_enable     = 1'b1;
        if_id_write_enable  = 1'b1;
        id_ex_write_enable  = 1'b1;
        ex_mem_write_enable = 1'b1;
        if_id_flush         = 1'b0;
        id_ex_flush         = 1'b0;
        ex_mem_flush        = 1'b0;
        mem_wb_flush        = 1'b0;
        stall_active        = 1'b0;

        if (dmem_busy) begin
            pc_write_enable     = 1'b0;
            if_id_write_enable  = 1'b0;
            id_ex_write_enable  = 1'b0;
            ex_mem_write_enable = 1'b0;
            mem_wb_flush        = 1'b1;
            stall_active        = 1'b1;
            state_d             = MEM_WAIT;
            ret_d               = eff_state;
            wait_cnt_d          = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d >= WAIT_MAX_C) timeout_d = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            branch_flush = 1'b1;
            state_d      = RUN;
            lu_cnt_d     = '0;
        end else if (eff_state == LU_HOLD) begin
            pc_write_enable    = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_flush        = 1'b1;
            stall_active       = 1'b1;
            if (lu_cnt_q <= 2'd1) begin
                state_d  = RUN;
                lu_cnt_d = '0;
            end else begin
                state_d  = LU_HOLD;
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end else begin
            state_d = RUN;
            if (lu_hazard) begin
                pc_write_enable    = 1'b0;
                if_id_write_enable = 1'b0;
                id_ex_flush        = 1'b1;
                stall_active       = 1'b1;
                if (LU_STALL > 1) begin
                    state_d  = LU_HOLD;
                    lu_cnt_d = LU_CNT_INIT;
                end
            end
        end

        // Held in reset: freeze every register and squash every stage.
        if (!rst_n) begin
            pc_write_enable     = 1'b0;
            if_id_write_enable  = 1'b0;
            id_ex_write_enable  = 1'b0;
            ex_mem_write_enable = 1'b0;
            if_id_flush         = 1'b1;
            id_ex_flush         = 1'b1;
            ex_mem_flush        = 1'b1;
            mem_wb_flush        = 1'b1;
            stall_active        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ret_q      <= RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (perf_clear) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_active && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (branch_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = perf_clear ^ branch_flush;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit: main instance LU_STALL=3, second instance LU_STALL=1.
module tb_hazard_ctrl_unit;
    // Control vector order: pc, if_id, id_ex, ex_mem enables; if_id, id_ex, ex_mem, mem_wb flushes; stall
    localparam logic [8:0] DEF = 9'b1111_0000_0;
    localparam logic [8:0] LU  = 9'b0011_0100_1;
    localparam logic [8:0] BR  = 9'b1111_1110_0;
    localparam logic [8:0] FRZ = 9'b0000_0001_1;
    localparam logic [8:0] RST = 9'b0000_1111_0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, mem_read_ex, branch_taken, dmem_busy, perf_clear;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
    logic        stall_active, mem_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [1:0]  state_dbg;

    logic [4:0]  b_rs1_id, b_rs2_id, b_rd_ex;
    logic        b_rs1_used, b_rs2_used, b_mem_read, b_branch, b_busy;
    logic        b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_if_id_fl, b_id_ex_fl, b_ex_mem_fl;
    logic        b_mem_wb_fl, b_stall, b_timeout;
    logic [31:0] b_perf_stall, b_perf_flush;
    logic [1:0]  b_state_dbg;

    hazard_ctrl_unit #(.REG_W(5), .LU_STALL(3), .MEM_WAIT_MAX(15), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .mem_read_ex(mem_read_ex),
        .rd_ex(rd_ex), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write_enable(pc_we), .if_id_write_enable(if_id_we), .id_ex_write_enable(id_ex_we),
        .ex_mem_write_enable(ex_mem_we), .if_id_flush(if_id_fl), .id_ex_flush(id_ex_fl),
        .ex_mem_flush(ex_mem_fl), .mem_wb_flush(mem_wb_fl), .stall_active(stall_active),
        .mem_timeout(mem_timeout), .perf_clear(perf_clear), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt), .state_dbg(state_dbg)
    );

    hazard_ctrl_unit #(.REG_W(5), .LU_STALL(1), .MEM_WAIT_MAX(15), .PERF_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs1_id(b_rs1_id), .rs2_id(b_rs2_id),
        .rs1_used_id(b_rs1_used), .rs2_used_id(b_rs2_used), .mem_read_ex(b_mem_read),
        .rd_ex(b_rd_ex), .branch_taken(b_branch), .dmem_busy(b_busy),
        .pc_write_enable(b_pc_we), .if_id_write_enable(b_if_id_we), .id_ex_write_enable(b_id_ex_we),
        .ex_mem_write_enable(b_ex_mem_we), .if_id_flush(b_if_id_fl), .id_ex_flush(b_id_ex_fl),
        .ex_mem_flush(b_ex_mem_fl), .mem_wb_flush(b_mem_wb_fl), .stall_active(b_stall),
        .mem_timeout(b_timeout), .perf_clear(1'b0), .perf_stall_cnt(b_perf_stall),
        .perf_flush_cnt(b_perf_flush), .state_dbg(b_state_dbg)
    );

`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic [9:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       exp_to = 1'b0;
    int         exp_stall = 0;
    int         exp_flush = 0;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_a(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        compare(tag, 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl,
                          mem_wb_fl, stall_active, mem_timeout}), 32'(e));
    endtask

    task automatic check_b(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        compare(tag, 32'({b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_if_id_fl, b_id_ex_fl,
                          b_ex_mem_fl, b_mem_wb_fl, b_stall, b_timeout}), 32'(e));
    endtask

    task automatic check_perf(input string tag);
        compare({tag, "_stall"}, perf_stall_cnt, PERF_ON ? 32'(exp_stall) : 32'd0);
        compare({tag, "_flush"}, perf_flush_cnt, PERF_ON ? 32'(exp_flush) : 32'd0);
    endtask

    // Called at a falling edge: drive, check mid-low-phase, clock, update counter model.
    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        input logic br, input logic busy, input logic [8:0] ctrl);
        mem_read_ex = mr; rd_ex = rd; rs1_id = r1; rs1_used_id = u1;
        rs2_id = r2; rs2_used_id = u2; branch_taken = br; dmem_busy = busy;
        exp_q.push_back({ctrl, exp_to});
        #2;
        check_a(tag);
        @(posedge clk);
        #1;
        if (perf_clear) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (ctrl[0]) exp_stall++;
            if (ctrl == BR) exp_flush++;
        end
        @(negedge clk);
    endtask

    task automatic step_b(input string tag, input logic mr, input logic [4:0] rd,
                          input logic [4:0] r1, input logic u1, input logic br, input logic [8:0] ctrl);
        b_mem_read = mr; b_rd_ex = rd; b_rs1_id = r1; b_rs1_used = u1; b_branch = br;
        exp_q.push_back({ctrl, 1'b0});
        #2;
        check_b(tag);
        @(negedge clk);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        exp_q.push_back({RST, 1'b0});
        check_a(tag);
        compare({tag, "_state"}, 32'(state_dbg), 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        check_perf({tag, "_perf"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; perf_clear = 1'b0;
        rs1_id = '0; rs2_id = '0; rd_ex = '0; rs1_used_id = 0; rs2_used_id = 0;
        mem_read_ex = 0; branch_taken = 0; dmem_busy = 0;
        b_rs1_id = '0; b_rs2_id = '0; b_rd_ex = '0; b_rs1_used = 0; b_rs2_used = 0;
        b_mem_read = 0; b_branch = 0; b_busy = 0;
        #2;
        exp_q.push_back({RST, 1'b0});
        check_a("reset_a");
        exp_q.push_back({RST, 1'b0});
        check_b("reset_b");
        check_perf("reset_perf");
        @(negedge clk);
        rst_n = 1'b1;

        // Multi-cycle load-use on rs1, then masking cases
        step("idle",      0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("lu_detect", 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        compare("state_hold", 32'(state_dbg), 32'd1);
        step("lu_hold1",  1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        step("lu_hold2",  1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        compare("state_run", 32'(state_dbg), 32'd0);
        step("lu_done",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("x0_nohaz",  1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, DEF);
        step("unused_rs", 1, 5'd5, 5'd5, 0, 5'd5, 0, 0, 0, DEF);
        step("rd_diff",   1, 5'd6, 5'd5, 1, 5'd7, 1, 0, 0, DEF);

        // rs2 hazard aborted by a branch during the hold
        step("lu_rs2",    1, 5'd9, 5'd1, 1, 5'd9, 1, 0, 0, LU);
        step("br_in_hold",0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, BR);
        compare("state_br", 32'(state_dbg), 32'd0);
        step("after_br",  0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("br_and_lu", 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, BR);
        step("no_hold",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);

        // Memory freeze in the middle of a load-use hold
        step("lu_detect2",1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        for (int i = 0; i < 4; i++) begin
            step("freeze",  1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, FRZ);
            compare("state_wait", 32'(state_dbg), 32'd2);
        end
        step("resume1",   1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        step("resume2",   1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        step("resume_end",0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);

        // Timeout: busy for 20 cycles; flag appears after the 15th and is sticky
        for (int i = 1; i <= 20; i++) begin
            exp_to = (i > 15);
            step("busy_to",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, FRZ);
        end
        step("to_sticky", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("to_sticky_br", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, BR);
        check_perf("perf_run");
        exp_to = 1'b0;
        mid_cycle_reset("to_reset");
        step("post_reset",0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);

        // Five stall cycles and two flush cycles, then clear
        step("p_lu0",     1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 0, LU);
        step("p_lu1",     1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 0, LU);
        step("p_lu2",     1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 0, LU);
        step("p_idle",    0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("p_busy0",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, FRZ);
        step("p_busy1",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, FRZ);
        step("p_release", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);
        step("p_br0",     0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, BR);
        step("p_br1",     0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, BR);
        check_perf("perf_5_2");
        perf_clear = 1'b1;
        step("p_clear_br",0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, BR);
        perf_clear = 1'b0;
        check_perf("perf_cleared");

        // Asynchronous reset in the middle of a load-use hold
        step("r_lu0",     1, 5'd4, 5'd0, 0, 5'd4, 1, 0, 0, LU);
        step("r_lu1",     1, 5'd4, 5'd0, 0, 5'd4, 1, 0, 0, LU);
        mem_read_ex = 0; rs2_used_id = 0;
        mid_cycle_reset("hold_reset");
        step("r_after",   0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, DEF);

        // Single-bubble instance
        step_b("b_idle",   0, 5'd0, 5'd0, 0, 0, DEF);
        step_b("b_lu",     1, 5'd5, 5'd5, 1, 0, LU);
        step_b("b_next",   0, 5'd0, 5'd0, 0, 0, DEF);
        step_b("b_x0",     1, 5'd0, 5'd0, 1, 0, DEF);
        step_b("b_lu_br",  1, 5'd5, 5'd5, 1, 1, BR);
        step_b("b_lu_again", 1, 5'd8, 5'd8, 1, 0, LU);
        step_b("b_lu_held",  1, 5'd8, 5'd8, 1, 0, LU);
        step_b("b_end",    0, 5'd0, 5'd0, 0, 0, DEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
